// File: rtl/mips_pkg.sv
// Shared definitions for the simple MIPS core: fetch FSM encoding, reset PC,
// and the opcode/funct fields decode uses to recognise j and jr.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HOLD   = 2'd2,
    ST_SQUASH = 2'd3
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] FUNCT_JR   = 6'h08;

endpackage

// File: rtl/next_pc_mux.sv
// Redirect target select for the fetch sequencer: j beats jr-less branch,
// and jump kind picks between pseudo-direct and register targets.
module next_pc_mux (
  input  logic        i_jump,
  input  logic        i_jump_addr_sel,
  input  logic [31:0] i_id_pc,
  input  logic [31:0] i_id_instr,
  input  logic [31:0] i_jr_target,
  input  logic [31:0] i_branch_target,
  output logic [31:0] o_target
);

  logic [31:0] w_pc_plus4;
  logic        w_unused;

  assign w_pc_plus4 = i_id_pc + 32'd4;
  // Only the region bits of pc+4 and the 26-bit index feed a j target.
  assign w_unused   = ^{w_pc_plus4[27:0], i_id_instr[31:26]};

  always_comb begin
    o_target = i_branch_target;
    if (i_jump) begin
      if (i_jump_addr_sel) begin
        o_target = i_jr_target;
      end else begin
        o_target = {w_pc_plus4[31:28], i_id_instr[25:0], 2'b00};
      end
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, runs the imem req/ready handshake,
// fills the decode slot, and redirects/squashes on taken jumps and branches.
module fetch_ctrl
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic [31:0] o_imem_addr,
  output logic        o_imem_req,
  input  logic        i_imem_ready,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_stall,
  input  logic        i_jump,
  input  logic        i_jump_addr_sel,
  input  logic [31:0] i_jr_target,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  output logic [31:0] o_id_instr,
  output logic [31:0] o_id_pc,
  output logic        o_id_valid,
  output logic        o_redirect
);

  fetch_state_e r_state;
  fetch_state_e w_state_next;

  logic [31:0] r_pc,         w_pc_next;
  logic [31:0] r_id_instr,   w_id_instr_next;
  logic [31:0] r_id_pc,      w_id_pc_next;
  logic        r_id_valid,   w_id_valid_next;
  logic [31:0] r_hold_instr, w_hold_instr_next;
  logic [31:0] r_hold_pc,    w_hold_pc_next;
  logic [31:0] r_sq_addr,    w_sq_addr_next;

  logic        w_accept;
  logic        w_take;
  logic [31:0] w_target;

  assign w_accept = !r_id_valid || !i_stall;
  assign w_take   = r_id_valid && !i_stall && (i_jump || i_branch_taken);

  next_pc_mux u_next_pc_mux (
    .i_jump          (i_jump),
    .i_jump_addr_sel (i_jump_addr_sel),
    .i_id_pc         (r_id_pc),
    .i_id_instr      (r_id_instr),
    .i_jr_target     (i_jr_target),
    .i_branch_target (i_branch_target),
    .o_target        (w_target)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_pc         <= RESET_PC;
      r_id_instr   <= 32'd0;
      r_id_pc      <= 32'd0;
      r_id_valid   <= 1'b0;
      r_hold_instr <= 32'd0;
      r_hold_pc    <= 32'd0;
      r_sq_addr    <= 32'd0;
    end else begin
      r_state      <= w_state_next;
      r_pc         <= w_pc_next;
      r_id_instr   <= w_id_instr_next;
      r_id_pc      <= w_id_pc_next;
      r_id_valid   <= w_id_valid_next;
      r_hold_instr <= w_hold_instr_next;
      r_hold_pc    <= w_hold_pc_next;
      r_sq_addr    <= w_sq_addr_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_pc_next         = r_pc;
    w_id_instr_next   = r_id_instr;
    w_id_pc_next      = r_id_pc;
    w_id_valid_next   = r_id_valid;
    w_hold_instr_next = r_hold_instr;
    w_hold_pc_next    = r_hold_pc;
    w_sq_addr_next    = r_sq_addr;

    case (r_state)
      ST_IDLE: begin
        w_state_next = ST_FETCH;
      end

      ST_FETCH: begin
        if (w_take) begin
          w_pc_next       = w_target;
          w_id_valid_next = 1'b0;
          // An unanswered wrong-path request must still be drained at its own address.
          if (!i_imem_ready) begin
            w_sq_addr_next = r_pc;
            w_state_next   = ST_SQUASH;
          end
        end else if (i_imem_ready) begin
          w_pc_next = r_pc + 32'd4;
          if (w_accept) begin
            w_id_instr_next = i_imem_rdata;
            w_id_pc_next    = r_pc;
            w_id_valid_next = 1'b1;
          end else begin
            w_hold_instr_next = i_imem_rdata;
            w_hold_pc_next    = r_pc;
            w_state_next      = ST_HOLD;
          end
        end
      end

      ST_HOLD: begin
        if (w_take) begin
          w_pc_next       = w_target;
          w_id_valid_next = 1'b0;
          w_state_next    = ST_FETCH;
        end else if (w_accept) begin
          w_id_instr_next = r_hold_instr;
          w_id_pc_next    = r_hold_pc;
          w_id_valid_next = 1'b1;
          w_state_next    = ST_FETCH;
        end
      end

      ST_SQUASH: begin
        if (i_imem_ready) begin
          w_state_next = ST_FETCH;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign o_imem_req  = (r_state == ST_FETCH) || (r_state == ST_SQUASH);
  assign o_imem_addr = (r_state == ST_SQUASH) ? r_sq_addr : r_pc;
  assign o_id_instr  = r_id_instr;
  assign o_id_pc     = r_id_pc;
  assign o_id_valid  = r_id_valid;
  assign o_redirect  = w_take;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed walk through the fetch scenarios, then random
// handshake/stall/redirect traffic checked against a slot/buffer reference model.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        stall = 1'b0;
  logic        jump = 1'b0;
  logic        jump_addr_sel = 1'b0;
  logic [31:0] jr_target = 32'd0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_valid;
  logic        redirect;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .o_imem_addr     (imem_addr),
    .o_imem_req      (imem_req),
    .i_imem_ready    (imem_ready),
    .i_imem_rdata    (imem_rdata),
    .i_stall         (stall),
    .i_jump          (jump),
    .i_jump_addr_sel (jump_addr_sel),
    .i_jr_target     (jr_target),
    .i_branch_taken  (branch_taken),
    .i_branch_target (branch_target),
    .o_id_instr      (id_instr),
    .o_id_pc         (id_pc),
    .o_id_valid      (id_valid),
    .o_redirect      (redirect)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Reference model: a started flag, the decode slot, an optional buffered
  // response, and an optional outstanding wrong-path request.
  bit          m_started;
  logic [31:0] m_pc;
  bit          m_v;
  logic [31:0] m_instr, m_idpc;
  bit          m_hv;
  logic [31:0] m_hinstr, m_hpc;
  bit          m_sq;
  logic [31:0] m_sqaddr;

  task automatic model_reset();
    m_started = 0; m_pc = 32'h0; m_v = 0; m_instr = 0; m_idpc = 0;
    m_hv = 0; m_hinstr = 0; m_hpc = 0; m_sq = 0; m_sqaddr = 0;
  endtask

  function automatic bit m_req();
    return m_started && !m_hv;
  endfunction

  function automatic logic [31:0] m_addr();
    return m_sq ? m_sqaddr : m_pc;
  endfunction

  function automatic logic [31:0] m_target(input bit jmp, input bit sel,
                                           input logic [31:0] jrt, input logic [31:0] brt);
    logic [31:0] p4;
    p4 = m_idpc + 32'd4;
    if (!jmp) return brt;
    if (sel) return jrt;
    return {p4[31:28], m_instr[25:0], 2'b00};
  endfunction

  task automatic check_outputs(input bit exp_redirect);
    chk("imem_req", {31'd0, imem_req}, {31'd0, m_req()});
    if (m_req()) chk("imem_addr", imem_addr, m_addr());
    chk("id_valid", {31'd0, id_valid}, {31'd0, m_v});
    chk("id_pc", id_pc, m_idpc);
    chk("id_instr", id_instr, m_instr);
    chk("redirect", {31'd0, redirect}, {31'd0, exp_redirect});
  endtask

  // One clock: drive at the negedge, check mid-low-phase, advance model at posedge.
  task automatic cyc(input bit rdy, input bit stl, input bit jmp, input bit sel, input bit br,
                     input logic [31:0] jrt, input logic [31:0] brt, input logic [31:0] rdat);
    bit          tk;
    logic [31:0] tgt;
    imem_ready = rdy; stall = stl; jump = jmp; jump_addr_sel = sel;
    branch_taken = br; jr_target = jrt; branch_target = brt; imem_rdata = rdat;
    tk  = m_v && !stl && (jmp || br);
    tgt = m_target(jmp, sel, jrt, brt);
    #1;
    check_outputs(tk);
    @(posedge clk);
    if (!m_started) begin
      m_started = 1;
    end else if (m_sq) begin
      if (rdy) m_sq = 0;
    end else if (m_hv) begin
      if (tk) begin
        m_hv = 0; m_pc = tgt; m_v = 0;
      end else if (!stl) begin
        m_v = 1; m_instr = m_hinstr; m_idpc = m_hpc; m_hv = 0;
      end
    end else if (tk) begin
      if (!rdy) begin
        m_sq = 1; m_sqaddr = m_pc;
      end
      m_pc = tgt; m_v = 0;
    end else if (rdy) begin
      if (!m_v || !stl) begin
        m_v = 1; m_instr = rdat; m_idpc = m_pc;
      end else begin
        m_hv = 1; m_hinstr = rdat; m_hpc = m_pc;
      end
      m_pc = m_pc + 32'd4;
    end
    @(negedge clk);
  endtask

  // Called at a negedge; asserts reset between edges and checks it takes effect at once.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0000_0000);
    chk("rst_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_instr", id_instr, 32'd0);
    chk("rst_idpc", id_pc, 32'd0);
    chk("rst_redirect", {31'd0, redirect}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit rdy, stl, jmp, sel, br;
    model_reset();
    @(negedge clk);
    do_reset();

    // Reset release with zero-wait memory
    cyc(1, 0, 0, 0, 0, 0, 0, 32'h1);
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    cyc(1, 0, 0, 0, 0, 0, 0, 32'h1);
    chk("seq_idpc0", id_pc, 32'h0);
    chk("seq_addr4", imem_addr, 32'h4);
    cyc(1, 0, 0, 0, 0, 0, 0, 32'h2);
    chk("seq_idpc4", id_pc, 32'h4);
    cyc(1, 0, 0, 0, 0, 0, 0, 32'h3);
    chk("seq_idpc8", id_pc, 32'h8);

    // Branch to 0x00400010, fetch a j with index 0x100 there
    cyc(1, 0, 0, 0, 1, 0, 32'h0040_0010, 32'h4);
    chk("br_addr", imem_addr, 32'h0040_0010);
    chk("br_flush", {31'd0, id_valid}, 32'd0);
    cyc(1, 0, 0, 0, 0, 0, 0, 32'h0800_0100);
    chk("j_idpc", id_pc, 32'h0040_0010);
    cyc(1, 0, 1, 0, 0, 0, 0, 32'h5);
    chk("j_addr", imem_addr, 32'h0000_0400);
    chk("j_flush", {31'd0, id_valid}, 32'd0);

    // jr while the next request is still waiting on memory
    cyc(1, 0, 0, 0, 0, 0, 0, 32'h11);
    cyc(0, 0, 1, 1, 0, 32'h1234, 0, 32'h0);
    chk("sq_addr", imem_addr, 32'h404);
    chk("sq_req", {31'd0, imem_req}, 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 0, 32'h0);
    cyc(1, 0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF);
    chk("jr_addr", imem_addr, 32'h1234);
    chk("sq_dropped", {31'd0, id_valid}, 32'd0);

    // Stall with ready high: response parks in the hold buffer
    cyc(1, 0, 0, 0, 0, 0, 0, 32'h21);
    cyc(1, 1, 0, 0, 0, 0, 0, 32'h22);
    chk("hold_req", {31'd0, imem_req}, 32'd0);
    cyc(0, 1, 0, 0, 0, 0, 0, 32'h0);
    cyc(0, 1, 0, 0, 0, 0, 0, 32'h0);
    chk("hold_idpc", id_pc, 32'h1234);
    cyc(0, 0, 0, 0, 0, 0, 0, 32'h0);
    chk("rel_idpc", id_pc, 32'h1238);
    chk("rel_instr", id_instr, 32'h22);
    chk("rel_addr", imem_addr, 32'h123C);

    // Reset in the middle of a squash
    cyc(1, 0, 0, 0, 0, 0, 0, 32'h31);
    cyc(0, 0, 0, 0, 1, 0, 32'h80, 32'h0);
    do_reset();
    cyc(1, 0, 0, 0, 0, 0, 0, 32'h41);
    chk("restart_addr", imem_addr, 32'h0);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        rdy = m_req() && ($urandom_range(0, 2) != 0);
        stl = ($urandom_range(0, 2) == 0);
        jmp = ($urandom_range(0, 7) == 0);
        sel = $urandom_range(0, 1) == 1;
        br  = ($urandom_range(0, 7) == 0);
        cyc(rdy, stl, jmp, sel, br, $urandom, $urandom, $urandom);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
